// File: rtl/ysyx_24100005_mem_arb.sv
// Two-requester (fetch, load/store) arbiter and single-transaction sequencer for the shared memory port.
// Define YSYX_24100005_ARB_RR_EN for round-robin ties; otherwise load/store wins every tie.
module ysyx_24100005_mem_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_valid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_ready,
    output logic        ifu_rvalid,
    input  logic        lsu_valid,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_ready,
    output logic        lsu_rvalid,
    output logic [31:0] rdata,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic        grant_ifu_s, grant_lsu_s;
    logic        resp_s;

`ifdef YSYX_24100005_ARB_RR_EN
    logic        last_q, last_d;
`endif

    // State, owner and latched request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IFU;
            we_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            wmask_q <= 8'h00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

`ifdef YSYX_24100005_ARB_RR_EN
    // Remembers which requester won the most recent grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OWN_IFU;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Grant selection, next-state and combinational handshake outputs.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        grant_ifu_s = 1'b0;
        grant_lsu_s = 1'b0;

        // Readies are gated by rst so every output reads 0 while reset is held.
        if (rst && (state_q == S_IDLE)) begin
            if (ifu_valid && lsu_valid) begin
`ifdef YSYX_24100005_ARB_RR_EN
                if (last_q == OWN_LSU) begin
                    grant_ifu_s = 1'b1;
                end else begin
                    grant_lsu_s = 1'b1;
                end
`else
                grant_lsu_s = 1'b1;
`endif
            end else if (lsu_valid) begin
                grant_lsu_s = 1'b1;
            end else if (ifu_valid) begin
                grant_ifu_s = 1'b1;
            end else begin
                grant_ifu_s = 1'b0;
            end
        end else begin
            grant_ifu_s = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (grant_lsu_s) begin
                    owner_d = OWN_LSU;
                    we_d    = lsu_we;
                    addr_d  = lsu_addr;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                    state_d = S_ISSUE;
                end else if (grant_ifu_s) begin
                    owner_d = OWN_IFU;
                    we_d    = 1'b0;
                    addr_d  = ifu_addr;
                    wdata_d = 32'h0000_0000;
                    wmask_d = 8'h00;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef YSYX_24100005_ARB_RR_EN
        if (grant_lsu_s) begin
            last_d = OWN_LSU;
        end else if (grant_ifu_s) begin
            last_d = OWN_IFU;
        end else begin
            last_d = last_q;
        end
`endif

        resp_s     = (state_q == S_WAIT) && mem_rvalid;
        ifu_ready  = grant_ifu_s;
        lsu_ready  = grant_lsu_s;
        ifu_rvalid = resp_s && (owner_q == OWN_IFU);
        lsu_rvalid = resp_s && (owner_q == OWN_LSU);
        rdata      = resp_s ? mem_rdata : 32'h0000_0000;
        mem_valid  = (state_q == S_ISSUE);
        busy       = (state_q != S_IDLE);
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_ysyx_24100005_mem_arb.sv
// Self-checking bench for ysyx_24100005_mem_arb: directed scenarios plus randomized traffic
// checked against a transaction-level model of the grant policy and response routing.
module tb_ysyx_24100005_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_valid, ifu_ready, ifu_rvalid;
    logic [31:0] ifu_addr;
    logic        lsu_valid, lsu_we, lsu_ready, lsu_rvalid;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic [31:0] rdata;
    logic        mem_valid, mem_we, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit last_lsu = 1'b0;

    always #5 clk = ~clk;

    ysyx_24100005_mem_arb dut (
        .clk(clk), .rst(rst),
        .ifu_valid(ifu_valid), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready), .ifu_rvalid(ifu_rvalid),
        .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_ready(lsu_ready), .lsu_rvalid(lsu_rvalid),
        .rdata(rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Grant policy as stated: a lone requester wins; ties go to lsu (fixed) or the non-last (round-robin).
    function automatic bit model_pick_lsu(input bit iv, input bit lv, input bit last);
        if (iv && lv) begin
`ifdef YSYX_24100005_ARB_RR_EN
            return !last;
`else
            return 1'b1;
`endif
        end
        return lv;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_ifu_ready"}, ifu_ready, 0);
        chk({tag, "_lsu_ready"}, lsu_ready, 0);
        chk({tag, "_ifu_rvalid"}, ifu_rvalid, 0);
        chk({tag, "_lsu_rvalid"}, lsu_rvalid, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_mem_valid"}, mem_valid, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_wmask"}, mem_wmask, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_fields(input string tag, input bit own_lsu, input logic [31:0] ea,
                                input bit ew, input logic [31:0] ewd, input logic [7:0] em);
        chk({tag, "_mem_addr"}, mem_addr, ea);
        chk({tag, "_mem_we"}, mem_we, ew);
        chk({tag, "_mem_wmask"}, mem_wmask, em);
        if (own_lsu) chk({tag, "_mem_wdata"}, mem_wdata, ewd);
    endtask

    // One full transaction starting in IDLE just after a posedge, with the caller's valids set.
    task automatic run_txn(input int stall, input int lat, input bit spurious,
                           input logic [31:0] resp, output bit own_lsu);
        logic [31:0] ea, ewd;
        logic [7:0]  em;
        bit          ew;
        own_lsu  = model_pick_lsu(ifu_valid, lsu_valid, last_lsu);
        last_lsu = own_lsu;
        ea  = own_lsu ? lsu_addr : ifu_addr;
        ew  = own_lsu ? lsu_we : 1'b0;
        ewd = lsu_wdata;
        em  = own_lsu ? lsu_wmask : 8'h00;
        #1;
        chk("accept_ifu_ready", ifu_ready, !own_lsu);
        chk("accept_lsu_ready", lsu_ready, own_lsu);
        chk("accept_busy", busy, 0);
        @(posedge clk); #1;
        if (own_lsu) lsu_valid = 1'b0; else ifu_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            mem_ready  = 1'b0;
            mem_rvalid = spurious;
            mem_rdata  = $urandom;
            #1;
            chk("stall_mem_valid", mem_valid, 1);
            check_fields("stall", own_lsu, ea, ew, ewd, em);
            chk("stall_ifu_rvalid", ifu_rvalid, 0);
            chk("stall_lsu_rvalid", lsu_rvalid, 0);
            chk("stall_ifu_ready", ifu_ready, 0);
            chk("stall_lsu_ready", lsu_ready, 0);
            chk("stall_busy", busy, 1);
            @(posedge clk); #1;
        end
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        #1;
        chk("issue_mem_valid", mem_valid, 1);
        check_fields("issue", own_lsu, ea, ew, ewd, em);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int i = 0; i < lat; i++) begin
            #1;
            chk("wait_mem_valid", mem_valid, 0);
            chk("wait_ifu_rvalid", ifu_rvalid, 0);
            chk("wait_lsu_rvalid", lsu_rvalid, 0);
            chk("wait_busy", busy, 1);
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = resp;
        #1;
        chk("resp_ifu_rvalid", ifu_rvalid, !own_lsu);
        chk("resp_lsu_rvalid", lsu_rvalid, own_lsu);
        chk("resp_rdata", rdata, resp);
        chk("resp_mem_valid", mem_valid, 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        #1;
        chk("retire_busy", busy, 0);
        chk("retire_ifu_rvalid", ifu_rvalid, 0);
        chk("retire_lsu_rvalid", lsu_rvalid, 0);
        chk("retire_rdata", rdata, 0);
    endtask

    initial begin
        bit own;
        bit exp_tie;
        rst = 1'b0;
        ifu_valid = 1'b1; ifu_addr = 32'h1234_5678;
        lsu_valid = 1'b0; lsu_we = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 8'h00;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        check_all_zero("reset");
        ifu_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        last_lsu = 1'b0;

        // Minimum-latency fetch.
        ifu_valid = 1'b1; ifu_addr = 32'h8000_0000;
        run_txn(0, 0, 1'b0, 32'h0010_0093, own);

        // Store with memory back-pressure for three cycles.
        lsu_valid = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h8000_0100;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
        run_txn(3, 0, 1'b0, 32'h5555_AAAA, own);

        // Spurious response in IDLE, then in ISSUE.
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("idle_spur_ifu_rvalid", ifu_rvalid, 0);
        chk("idle_spur_lsu_rvalid", lsu_rvalid, 0);
        chk("idle_spur_rdata", rdata, 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        #1;
        chk("idle_spur_busy", busy, 0);
        ifu_valid = 1'b1; ifu_addr = 32'h8000_0004;
        run_txn(2, 1, 1'b1, 32'hCAFE_F00D, own);

        // Both requesters valid for four transactions.
        for (int k = 0; k < 4; k++) begin
            ifu_valid = 1'b1; ifu_addr = $urandom;
            lsu_valid = 1'b1; lsu_we = 1'($urandom_range(0, 1));
            lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 8'($urandom);
`ifdef YSYX_24100005_ARB_RR_EN
            exp_tie = (k % 2 == 0);
`else
            exp_tie = 1'b1;
`endif
            run_txn(0, 0, 1'b0, $urandom, own);
            chk("tie_grant_is_lsu", own, exp_tie);
        end
        ifu_valid = 1'b0; lsu_valid = 1'b0;

        // Reset during WAIT.
        ifu_valid = 1'b1; ifu_addr = 32'h8000_0040;
        #1;
        chk("rstw_accept", ifu_ready, 1);
        @(posedge clk); #1;
        ifu_valid = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1;
        chk("rstw_busy_before", busy, 1);
        lsu_valid = 1'b1; lsu_addr = 32'h0000_0010;
        rst = 1'b0;
        #1;
        check_all_zero("rstw");
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        rst = 1'b1;
        last_lsu = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        chk("rstw_post_ifu_rvalid", ifu_rvalid, 0);
        chk("rstw_post_lsu_rvalid", lsu_rvalid, 0);
        chk("rstw_post_busy", busy, 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        #1;
        chk("rstw_post_busy2", busy, 0);

        // Randomized traffic; a waiting requester keeps its request fields until granted.
        for (int n = 0; n < 40; n++) begin
            if (!ifu_valid && ($urandom_range(0, 1) == 1)) begin
                ifu_valid = 1'b1; ifu_addr = $urandom;
            end
            if (!lsu_valid && ($urandom_range(0, 1) == 1)) begin
                lsu_valid = 1'b1; lsu_we = 1'($urandom_range(0, 1));
                lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 8'($urandom);
            end
            if (!ifu_valid && !lsu_valid) begin
                ifu_valid = 1'b1; ifu_addr = $urandom;
            end
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, own);
        end
        ifu_valid = 1'b0; lsu_valid = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
